// File: rtl/ttt_result_checker.sv
// Tic-tac-toe result checker: scans a snapshot of the board one winning line per clock,
// then reports winner, draw, board-full and illegal-cell status and keeps saturating win tallies.
module ttt_result_checker #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [17:0]        board,
    input  logic               new_game,
    output logic               result_valid,
    output logic [1:0]         winner,
    output logic [2:0]         win_line,
    output logic               draw,
    output logic               no_space,
    output logic               game_over,
    output logic               cell_error,
    output logic [SCORE_W-1:0] plyr_score,
    output logic [SCORE_W-1:0] comp_score
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Cell numbers (1..9) of each winning line, packed {third, second, first}.
    function automatic logic [11:0] line_cells(input int idx);
        case (idx)
            0:       return {4'd3, 4'd2, 4'd1};
            1:       return {4'd6, 4'd5, 4'd4};
            2:       return {4'd9, 4'd8, 4'd7};
            3:       return {4'd7, 4'd4, 4'd1};
            4:       return {4'd8, 4'd5, 4'd2};
            5:       return {4'd9, 4'd6, 4'd3};
            6:       return {4'd9, 4'd5, 4'd1};
            default: return {4'd7, 4'd5, 4'd3};
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [17:0]        snap_q, snap_d;
    logic [2:0]         line_idx_q, line_idx_d;
    logic [1:0]         found_winner_q, found_winner_d;
    logic [2:0]         found_line_q, found_line_d;
    logic               result_valid_q, result_valid_d;
    logic [1:0]         winner_q, winner_d;
    logic [2:0]         win_line_q, win_line_d;
    logic               draw_q, draw_d;
    logic               no_space_q, no_space_d;
    logic               game_over_q, game_over_d;
    logic               cell_error_q, cell_error_d;
    logic [SCORE_W-1:0] plyr_score_q, plyr_score_d;
    logic [SCORE_W-1:0] comp_score_q, comp_score_d;

    logic [7:0] line_win;
    logic [1:0] line_color [8];
    logic [8:0] cell_empty;
    logic [8:0] cell_bad;
    logic       snap_full;
    logic       snap_err;
    logic       report_draw;
    logic       report_over;

    // Win detection only ever looks at the snapshot, so the live board may move mid-scan.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            localparam logic [11:0] LC = line_cells(gi);
            localparam int C0 = int'(LC[3:0]) - 1;
            localparam int C1 = int'(LC[7:4]) - 1;
            localparam int C2 = int'(LC[11:8]) - 1;
            logic [1:0] ca, cb, cc;
            assign ca = snap_q[2*C0 +: 2];
            assign cb = snap_q[2*C1 +: 2];
            assign cc = snap_q[2*C2 +: 2];
            assign line_win[gi]   = (ca == cb) && (cb == cc) && ((ca == 2'b01) || (ca == 2'b10));
            assign line_color[gi] = ca;
        end
        for (genvar gi = 0; gi < 9; gi++) begin : g_cell
            assign cell_empty[gi] = (snap_q[2*gi +: 2] == 2'b00);
            assign cell_bad[gi]   = (snap_q[2*gi +: 2] == 2'b11);
        end
    endgenerate

    assign snap_full   = ~|cell_empty;
    assign snap_err    = |cell_bad;
    assign report_draw = snap_full && (found_winner_q == 2'b00);
    assign report_over = (found_winner_q != 2'b00) || report_draw;

    always_comb begin
        state_d        = state_q;
        snap_d         = snap_q;
        line_idx_d     = line_idx_q;
        found_winner_d = found_winner_q;
        found_line_d   = found_line_q;
        result_valid_d = 1'b0;
        winner_d       = winner_q;
        win_line_d     = win_line_q;
        draw_d         = draw_q;
        no_space_d     = no_space_q;
        game_over_d    = game_over_q;
        cell_error_d   = cell_error_q;
        plyr_score_d   = plyr_score_q;
        comp_score_d   = comp_score_q;

        case (state_q)
            IDLE: begin
                if (board != snap_q) begin
                    snap_d         = board;
                    line_idx_d     = 3'd0;
                    found_winner_d = 2'b00;
                    found_line_d   = 3'd0;
                    state_d        = SCAN;
                end
            end
            SCAN: begin
                if (line_win[line_idx_q]) begin
                    found_winner_d = line_color[line_idx_q];
                    found_line_d   = line_idx_q;
                    state_d        = REPORT;
                end else if (line_idx_q == 3'd7) begin
                    found_winner_d = 2'b00;
                    found_line_d   = 3'd0;
                    state_d        = REPORT;
                end else begin
                    line_idx_d = line_idx_q + 3'd1;
                end
            end
            REPORT: begin
                result_valid_d = 1'b1;
                winner_d       = found_winner_q;
                win_line_d     = found_line_q;
                no_space_d     = snap_full;
                cell_error_d   = snap_err;
                draw_d         = report_draw;
                game_over_d    = report_over;
                if (found_winner_q == 2'b01 && plyr_score_q != SCORE_MAX)
                    plyr_score_d = plyr_score_q + 1'b1;
                if (found_winner_q == 2'b10 && comp_score_q != SCORE_MAX)
                    comp_score_d = comp_score_q + 1'b1;
                state_d = report_over ? OVER : IDLE;
            end
            default: begin
                // OVER: everything holds until new_game.
            end
        endcase

        // new_game overrides whatever the FSM decided this cycle, including a REPORT.
        if (new_game) begin
            state_d        = IDLE;
            snap_d         = board;
            line_idx_d     = 3'd0;
            result_valid_d = 1'b0;
            winner_d       = 2'b00;
            win_line_d     = 3'd0;
            draw_d         = 1'b0;
            no_space_d     = 1'b0;
            game_over_d    = 1'b0;
            cell_error_d   = 1'b0;
            plyr_score_d   = plyr_score_q;
            comp_score_d   = comp_score_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            snap_q         <= '0;
            line_idx_q     <= '0;
            found_winner_q <= '0;
            found_line_q   <= '0;
            result_valid_q <= 1'b0;
            winner_q       <= '0;
            win_line_q     <= '0;
            draw_q         <= 1'b0;
            no_space_q     <= 1'b0;
            game_over_q    <= 1'b0;
            cell_error_q   <= 1'b0;
            plyr_score_q   <= '0;
            comp_score_q   <= '0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            line_idx_q     <= line_idx_d;
            found_winner_q <= found_winner_d;
            found_line_q   <= found_line_d;
            result_valid_q <= result_valid_d;
            winner_q       <= winner_d;
            win_line_q     <= win_line_d;
            draw_q         <= draw_d;
            no_space_q     <= no_space_d;
            game_over_q    <= game_over_d;
            cell_error_q   <= cell_error_d;
            plyr_score_q   <= plyr_score_d;
            comp_score_q   <= comp_score_d;
        end
    end

    assign result_valid = result_valid_q;
    assign winner       = winner_q;
    assign win_line     = win_line_q;
    assign draw         = draw_q;
    assign no_space     = no_space_q;
    assign game_over    = game_over_q;
    assign cell_error   = cell_error_q;
    assign plyr_score   = plyr_score_q;
    assign comp_score   = comp_score_q;

endmodule

// File: tb/tb_ttt_result_checker.sv
// Directed bench for ttt_result_checker: each task drives one scenario and checks
// hand-derived latencies and result fields.
module tb_ttt_result_checker;

    localparam int SCORE_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [17:0]        board = '0;
    logic               new_game = 1'b0;
    logic               result_valid;
    logic [1:0]         winner;
    logic [2:0]         win_line;
    logic               draw;
    logic               no_space;
    logic               game_over;
    logic               cell_error;
    logic [SCORE_W-1:0] plyr_score;
    logic [SCORE_W-1:0] comp_score;

    int tests  = 0;
    int failed = 0;

    ttt_result_checker #(.SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .board(board), .new_game(new_game),
        .result_valid(result_valid), .winner(winner), .win_line(win_line),
        .draw(draw), .no_space(no_space), .game_over(game_over),
        .cell_error(cell_error), .plyr_score(plyr_score), .comp_score(comp_score)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input logic [1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9);
        return {c9, c8, c7, c6, c5, c4, c3, c2, c1};
    endfunction

    localparam logic [17:0] ROW1     = 18'h00015;
    localparam logic [17:0] COMP_ROW = 18'h00A80;
    localparam logic [17:0] ILLEGAL  = 18'h0003F;

    // Cells of the board the DUT should act on; X = player (01), O = computer (10).
    logic [17:0] diag_b, draw_b, nowin_b, line2_b;

    task automatic apply_board(input logic [17:0] v);
        @(negedge clk);
        board = v;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Counts edges after the board was applied; lat = edges after the sampling edge.
    task automatic wait_rv(input int max_cyc, output int lat, output bit found);
        found = 1'b0;
        lat   = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat   = c - 1;
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({result_valid, winner, win_line, draw, no_space, game_over, cell_error, plyr_score, comp_score} !== '0) begin
            $display("FAIL reset_outputs: got rv=%0b w=%0h l=%0d d=%0b ns=%0b go=%0b ce=%0b p=%0d c=%0d, expected all 0",
                     result_valid, winner, win_line, draw, no_space, game_over, cell_error, plyr_score, comp_score);
            failed++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_player_row();
        int lat; bit found;
        apply_board(ROW1);
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 2) begin $display("FAIL row_latency: got %0d, expected 2", lat); failed++; end
        tests++; if (winner !== 2'b01) begin $display("FAIL row_winner: got %0h, expected 1", winner); failed++; end
        tests++; if (win_line !== 3'd0) begin $display("FAIL row_line: got %0d, expected 0", win_line); failed++; end
        tests++; if (game_over !== 1'b1 || draw !== 1'b0) begin $display("FAIL row_over: got go=%0b d=%0b, expected go=1 d=0", game_over, draw); failed++; end
        tests++; if (plyr_score !== 4'd1 || comp_score !== 4'd0) begin $display("FAIL row_score: got p=%0d c=%0d, expected p=1 c=0", plyr_score, comp_score); failed++; end
        tests++; if (no_space !== 1'b0 || cell_error !== 1'b0) begin $display("FAIL row_flags: got ns=%0b ce=%0b, expected 0 0", no_space, cell_error); failed++; end
        @(posedge clk); #1;
        tests++; if (result_valid !== 1'b0) begin $display("FAIL row_pulse_width: got rv=%0b, expected 0", result_valid); failed++; end
    endtask

    task automatic test_over_hold();
        int lat; bit found;
        apply_board(COMP_ROW);
        wait_rv(12, lat, found);
        tests++; if (found) begin $display("FAIL over_hold_rv: got pulse at %0d, expected none", lat); failed++; end
        tests++; if (winner !== 2'b01 || game_over !== 1'b1) begin $display("FAIL over_hold_outputs: got w=%0h go=%0b, expected w=1 go=1", winner, game_over); failed++; end
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        tests++;
        if (winner !== 2'b00 || game_over !== 1'b0 || win_line !== 3'd0 || result_valid !== 1'b0) begin
            $display("FAIL new_game_clear: got w=%0h go=%0b l=%0d rv=%0b, expected all 0", winner, game_over, win_line, result_valid);
            failed++;
        end
        tests++; if (plyr_score !== 4'd1) begin $display("FAIL new_game_keeps_score: got %0d, expected 1", plyr_score); failed++; end
        apply_board('0);
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 9) begin $display("FAIL empty_latency: got %0d, expected 9", lat); failed++; end
        tests++;
        if (winner !== 2'b00 || no_space !== 1'b0 || game_over !== 1'b0 || draw !== 1'b0) begin
            $display("FAIL empty_result: got w=%0h ns=%0b go=%0b d=%0b, expected all 0", winner, no_space, game_over, draw);
            failed++;
        end
    endtask

    task automatic test_comp_diag();
        int lat; bit found;
        apply_board(diag_b);
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 9) begin $display("FAIL diag_latency: got %0d, expected 9", lat); failed++; end
        tests++; if (winner !== 2'b10 || win_line !== 3'd7) begin $display("FAIL diag_result: got w=%0h l=%0d, expected w=2 l=7", winner, win_line); failed++; end
        tests++; if (comp_score !== 4'd1 || plyr_score !== 4'd1) begin $display("FAIL diag_score: got p=%0d c=%0d, expected p=1 c=1", plyr_score, comp_score); failed++; end
        pulse_new_game();
    endtask

    task automatic test_draw();
        int lat; bit found;
        apply_board(draw_b);
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 9) begin $display("FAIL draw_latency: got %0d, expected 9", lat); failed++; end
        tests++;
        if (winner !== 2'b00 || draw !== 1'b1 || no_space !== 1'b1 || game_over !== 1'b1) begin
            $display("FAIL draw_result: got w=%0h d=%0b ns=%0b go=%0b, expected w=0 d=1 ns=1 go=1", winner, draw, no_space, game_over);
            failed++;
        end
        tests++; if (plyr_score !== 4'd1 || comp_score !== 4'd1) begin $display("FAIL draw_score: got p=%0d c=%0d, expected p=1 c=1", plyr_score, comp_score); failed++; end
        pulse_new_game();
    endtask

    task automatic test_illegal();
        int lat; bit found;
        apply_board(ILLEGAL);
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 9) begin $display("FAIL illegal_latency: got %0d, expected 9", lat); failed++; end
        tests++;
        if (winner !== 2'b00 || cell_error !== 1'b1 || no_space !== 1'b0 || game_over !== 1'b0) begin
            $display("FAIL illegal_result: got w=%0h ce=%0b ns=%0b go=%0b, expected w=0 ce=1 ns=0 go=0", winner, cell_error, no_space, game_over);
            failed++;
        end
    endtask

    task automatic test_midscan_change();
        int lat; bit found;
        apply_board(nowin_b);
        repeat (3) @(posedge clk);
        @(negedge clk);
        board = ROW1;
        // Edges already elapsed since the sampling edge: 3 posedges, first one was the sample.
        wait_rv(20, lat, found);
        lat = lat + 3;
        tests++; if (!found || lat != 9) begin $display("FAIL midscan_first_latency: got %0d, expected 9", lat); failed++; end
        tests++; if (winner !== 2'b00 || no_space !== 1'b0) begin $display("FAIL midscan_first_result: got w=%0h ns=%0b, expected 0 0", winner, no_space); failed++; end
        wait_rv(20, lat, found);
        tests++; if (!found || lat != 2) begin $display("FAIL midscan_second_latency: got %0d, expected 2", lat); failed++; end
        tests++; if (winner !== 2'b01 || plyr_score !== 4'd2) begin $display("FAIL midscan_second_result: got w=%0h p=%0d, expected w=1 p=2", winner, plyr_score); failed++; end
    endtask

    task automatic test_new_game_in_report();
        int lat; bit found;
        pulse_new_game();
        apply_board('0);
        wait_rv(20, lat, found);
        tests++; if (!found) begin $display("FAIL ngr_setup: got no pulse, expected one"); failed++; end
        apply_board(ROW1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (result_valid !== 1'b0 || winner !== 2'b00 || game_over !== 1'b0 || plyr_score !== 4'd2) begin
            $display("FAIL new_game_in_report: got rv=%0b w=%0h go=%0b p=%0d, expected rv=0 w=0 go=0 p=2", result_valid, winner, game_over, plyr_score);
            failed++;
        end
        @(negedge clk);
        new_game = 1'b0;
        wait_rv(12, lat, found);
        tests++; if (found) begin $display("FAIL ngr_no_rescan: got pulse at %0d, expected none", lat); failed++; end
    endtask

    task automatic test_saturation();
        int lat; bit found;
        for (int i = 0; i < 13; i++) begin
            pulse_new_game();
            apply_board((i % 2 == 0) ? line2_b : ROW1);
            wait_rv(20, lat, found);
            tests++;
            if (!found || win_line !== ((i % 2 == 0) ? 3'd2 : 3'd0) || lat != ((i % 2 == 0) ? 4 : 2)) begin
                $display("FAIL sat_win_%0d: got line=%0d lat=%0d, expected line=%0d", i, win_line, lat, (i % 2 == 0) ? 2 : 0);
                failed++;
            end
        end
        tests++; if (plyr_score !== 4'd15) begin $display("FAIL sat_reach_max: got %0d, expected 15", plyr_score); failed++; end
        pulse_new_game();
        apply_board(ROW1);
        wait_rv(20, lat, found);
        tests++; if (!found || winner !== 2'b01) begin $display("FAIL sat_extra_win: got w=%0h, expected 1", winner); failed++; end
        tests++; if (plyr_score !== 4'd15 || comp_score !== 4'd1) begin $display("FAIL sat_hold: got p=%0d c=%0d, expected p=15 c=1", plyr_score, comp_score); failed++; end
    endtask

    task automatic test_reset_midscan();
        pulse_new_game();
        apply_board('0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({result_valid, winner, win_line, draw, no_space, game_over, cell_error, plyr_score, comp_score} !== '0) begin
            $display("FAIL reset_midscan: got w=%0h go=%0b p=%0d c=%0d, expected all 0", winner, game_over, plyr_score, comp_score);
            failed++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        diag_b  = mk(2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00);
        draw_b  = mk(2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01);
        nowin_b = mk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        line2_b = mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        test_reset();
        test_player_row();
        test_over_hold();
        test_comp_diag();
        test_draw();
        test_illegal();
        test_midscan_change();
        test_new_game_in_report();
        test_saturation();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ttt_result_checker.md
Name: ttt_result_checker

Overview:
- Sits directly downstream of the board-state register bank and consumes its nine 2-bit cell states.
- Scans the eight winning lines one per clock and reports the winner, draw and board-full status.
- Keeps saturating per-side win tallies.
- Its no_space output drives the board-state block's no_space input, which freezes marking once the game ends.

Parameters:
- SCORE_W, 4, width of each win counter; counters saturate at 2^SCORE_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- board  in  18  cell k (1..9) at bits [2k-1:2k-2]; encoding: 00 empty, 01 player, 10 computer, 11 illegal.
- new_game  in  1  single-cycle synchronous pulse; clears the current result and keeps the scores.
- result_valid  out  1  one-cycle pulse when a scan completes.
- winner  out  2  00 none, 01 player, 10 computer; held until the next scan result or clear.
- win_line  out  3  index of the winning line; 0 when there is no winner.
- draw  out  1  board full and no winner.
- no_space  out  1  registered; 1 when the last scanned snapshot has no 00 cell.
- game_over  out  1  winner!=00 or draw; sticky until new_game or reset.
- cell_error  out  1  last scanned snapshot contained a cell equal to 11.
- plyr_score  out  SCORE_W  player win count.
- comp_score  out  SCORE_W  computer win count.

Behaviour:
- Reset (async): every output is 0, snap=0, line_idx=0, state=IDLE.
- Line order:
  - 0: cells 1,2,3
  - 1: cells 4,5,6
  - 2: cells 7,8,9
  - 3: cells 1,4,7
  - 4: cells 2,5,8
  - 5: cells 3,6,9
  - 6: cells 1,5,9
  - 7: cells 3,5,7
- A line wins when all three cells are equal and equal to 01 or 10. A cell of 11 never matches.
- FSM states: IDLE, SCAN, REPORT, OVER.
- IDLE: if board!=snap, load snap<=board, set line_idx<=0, go to SCAN. Otherwise stay.
- SCAN: each cycle evaluate line line_idx of snap (never the live board).
  - Win: latch winner and win_line=line_idx, go to REPORT.
  - No win and line_idx==7: go to REPORT with winner=00.
  - Otherwise line_idx+1.
- REPORT (one cycle):
  - result_valid=1.
  - no_space=(no 00 cell in snap); cell_error=(any 11 cell in snap).
  - draw=no_space && winner==00.
  - game_over=winner!=00 || draw.
  - Increment the matching score on a win, saturating at max.
  - Next state: OVER if game_over, else IDLE.
- OVER: all outputs held; board changes are ignored.
- Latency: board change sampled at edge k; line 0 is evaluated at edge k+1.
  - Win on line i: REPORT cycle follows edge k+i+1.
  - No win: result_valid is high in the cycle after edge k+9 (max).
- Board changes during SCAN/REPORT do not disturb the scan. They are detected in IDLE afterwards because snap differs.
- Priority: new_game in any state clears winner, win_line, draw, no_space, game_over, cell_error and result_valid.
  - It also sets snap<=board and state<=IDLE. Scores are kept.
  - new_game in the same cycle as REPORT takes precedence: no result_valid pulse and no score increment.
- Simultaneous winning lines: the lowest index is reported.
- Reset mid-scan: immediate return to reset values, including scores.

Test Plan:
- Player row: from reset, board=18'h00015 (cells 1-3 = 01) -> result_valid pulse 2 cycles after the change edge; winner=01, win_line=0, game_over=1, plyr_score=1, no_space=0.
- Computer diagonal 3-5-7 with the other cells mixed and no other line -> result_valid 9 cycles after the change edge; winner=10, win_line=7, comp_score=1.
- Draw: board=X O X / X O O / O X X (no line), all cells non-zero -> winner=00, draw=1, no_space=1, game_over=1, scores unchanged.
- OVER hold then restart: after a win, change board -> no new result_valid; pulse new_game, then board=0 -> outputs cleared, scores kept; next win increments.
- Mid-scan effects:
  - Change board during SCAN of a no-win snapshot -> first result reflects the old snapshot, then a second scan starts.
  - Assert reset during SCAN -> all outputs 0 on the next sample.
- Saturation/illegal:
  - 15 player wins with SCORE_W=4, then one more -> plyr_score stays 15.
  - Cells 1-3 = 11 -> no win; cell_error=1.
